// File: rtl/iterative_divider.sv
// iterative_divider: signed 32-bit restoring divider; DIV_OVF_EXCEPTION_EN flags -2^31/-1 as an exception
module ripple_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s
);
    logic [W-1:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign s[i] = a[i] ^ b[i] ^ c[i];
        if (i < W - 1) begin : g_carry
            assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end
endmodule

module iterative_divider (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_next;
    logic [5:0] cnt;
    logic [31:0] rem, quo, div;
    logic neg, dz, ovf;
    logic [31:0] neg_a, neg_b, abs_a, abs_b, neg_q, final_q;
    logic [32:0] shifted, diff;
    logic [31:0] result_next;
    logic exception_next, rdy_next;

    ripple_adder #(.W(32)) u_neg_a (.a(~data_operandA), .b(32'd0), .cin(1'b1), .s(neg_a));
    ripple_adder #(.W(32)) u_neg_b (.a(~data_operandB), .b(32'd0), .cin(1'b1), .s(neg_b));
    ripple_adder #(.W(32)) u_neg_q (.a(~quo), .b(32'd0), .cin(1'b1), .s(neg_q));
    ripple_adder #(.W(33)) u_trial (.a(shifted), .b(~{1'b0, div}), .cin(1'b1), .s(diff));

    assign abs_a   = data_operandA[31] ? neg_a : data_operandA;
    assign abs_b   = data_operandB[31] ? neg_b : data_operandB;
    assign shifted = {rem, quo[31]};
    assign final_q = neg ? neg_q : quo;

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_next;
    end

    // a start strobe always wins, aborting any operation in flight
    always_comb begin
        state_next = ctrl_DIV ? (data_operandB == '0 ? DONE : RUN) :
                     state == RUN ? (cnt == 6'd31 ? DONE : RUN) : IDLE;
    end

    // operand capture and one restoring iteration per RUN cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rem <= '0;
            quo <= '0;
            div <= '0;
            neg <= 1'b0;
            dz  <= 1'b0;
            cnt <= '0;
        end else if (ctrl_DIV) begin
            rem <= '0;
            quo <= abs_a;
            div <= abs_b;
            neg <= data_operandA[31] ^ data_operandB[31];
            dz  <= data_operandB == '0;
            cnt <= '0;
        end else if (state == RUN) begin
            rem <= diff[32] ? shifted[31:0] : diff[31:0];
            quo <= {quo[30:0], ~diff[32]};
            cnt <= cnt + 6'd1;
        end
    end

`ifdef DIV_OVF_EXCEPTION_EN
    // remember whether the captured operands are the one overflowing pair
    always_ff @(posedge clock or posedge reset) begin
        if (reset) ovf <= 1'b0;
        else if (ctrl_DIV) ovf <= data_operandA == 32'h8000_0000 && data_operandB == 32'hFFFF_FFFF;
    end
`else
    assign ovf = 1'b0;
`endif

    // completion values; an abort in DONE suppresses the pulse
    always_comb begin
        rdy_next       = state == DONE && !ctrl_DIV;
        result_next    = rdy_next ? (dz ? 32'd0 : final_q) : data_result;
        exception_next = rdy_next && (dz || ovf);
    end

    // registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_result    <= result_next;
            data_exception <= exception_next;
            data_resultRDY <= rdy_next;
        end
    end
endmodule

// File: tb/tb_iterative_divider.sv
// tb_iterative_divider: directed and random checks of iterative_divider against an arithmetic model
module tb_iterative_divider;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    int tests = 0;
    int fails = 0;

    iterative_divider dut (
        .clock(clock),
        .reset(reset),
        .ctrl_DIV(ctrl_DIV),
        .data_operandA(data_operandA),
        .data_operandB(data_operandB),
        .data_result(data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_q(input logic [31:0] a, input logic [31:0] b);
        longint q;
        if (b == 0) return 32'd0;
        q = longint'($signed(a)) / longint'($signed(b));
        return q[31:0];
    endfunction

    function automatic logic model_e(input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_OVF_EXCEPTION_EN
        return b == 0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`else
        return b == 0;
`endif
    endfunction

    // called just after a negedge; the next posedge is the capture edge E0
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
        int lat;
        lat = -1;
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV = 1'b1;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (data_resultRDY) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, lat, b == 0 ? 1 : 33);
        check({tag, "_result"}, data_result, model_q(a, b));
        check({tag, "_exception"}, data_exception, model_e(a, b));
        @(negedge clock);
        check({tag, "_rdy_drop"}, data_resultRDY, 1'b0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int seen;
        #1;
        check("reset_result", data_result, 32'd0);
        check("reset_rdy", data_resultRDY, 1'b0);
        check("reset_exception", data_exception, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        run_op("pos_pos", 32'd100, 32'd7);
        run_op("neg_pos", -32'sd100, 32'd7);
        run_op("neg_neg", -32'sd100, -32'sd7);
        run_op("small", 32'd7, 32'd100);
        run_op("div_zero", 32'd5, 32'd0);
        run_op("overflow", 32'h8000_0000, 32'hFFFF_FFFF);
        data_operandA = 32'd100;
        data_operandB = 32'd7;
        ctrl_DIV = 1'b1;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        seen = 0;
        repeat (9) begin
            @(negedge clock);
            if (data_resultRDY) seen++;
        end
        check("abort_no_rdy", seen, 0);
        run_op("abort_restart", 32'd50, 32'd5);
        data_operandA = 32'd100;
        data_operandB = 32'd7;
        ctrl_DIV = 1'b1;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        repeat (14) @(negedge clock);
        reset = 1'b1;
        #1;
        check("midreset_result", data_result, 32'd0);
        check("midreset_rdy", data_resultRDY, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY) seen++;
        end
        check("midreset_no_rdy", seen, 0);
        run_op("after_reset", 32'd9, 32'd3);
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 50);
                2: rb = -$urandom_range(1, 50);
                3: ra = $urandom_range(0, 1000);
                default: ;
            endcase
            run_op($sformatf("rand%0d", i), ra, rb);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
